// File: rtl/conv_pkg.sv
// conv_pkg: shared kernel codes, FSM encoding and widths for the 3x3 convolution path
package conv_pkg;
  localparam int PIX_W = 8;
  localparam int WIN_W = 72;
  localparam logic [1:0] K_CLEAR = 2'd0;
  localparam logic [1:0] K_SOBX = 2'd1;
  localparam logic [1:0] K_SOBY = 2'd2;
  localparam logic [1:0] K_BLUR = 2'd3;
  typedef enum logic [2:0] {IDLE, FILL, CALC, CAPT, HOLD, DONE} state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixels, written on accept and read at the current column
module line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] col,
  input  logic [PIX_W-1:0]         wdata,
  output logic [PIX_W-1:0]         rdata
);
  logic [PIX_W-1:0] mem [IMG_W];
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < IMG_W; i++) mem[i] <= '0;
    else if (we)
      mem[col] <= wdata;
  assign rdata = mem[col];
endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster pixel stream to 3x3 windows, sequences the convolution datapath per window
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       kernel_sel,
  output logic             busy,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [WIN_W-1:0] win_data,
  output logic [1:0]       kern_sel_q,
  input  logic [PIX_W-1:0] conv_data,
  output logic [PIX_W-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_last,
  output logic             frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [PIX_W-1:0] lb0, lb1;
  logic acc, win_ok, col_end;
  assign acc = pix_valid && pix_ready;
  assign win_ok = row >= RW'(2) && col >= CW'(2);
  assign col_end = col == CW'(IMG_W - 1);
  line_buffer #(.IMG_W(IMG_W)) u_lb0 (
    .clk(clk), .reset(reset), .we(acc), .col(col), .wdata(pix_data), .rdata(lb0)
  );
  line_buffer #(.IMG_W(IMG_W)) u_lb1 (
    .clk(clk), .reset(reset), .we(acc), .col(col), .wdata(lb0), .rdata(lb1)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? FILL : IDLE;
      FILL: state_n = (acc && win_ok) ? CALC : FILL;
      CALC: state_n = CAPT;
      CAPT: state_n = HOLD;
      HOLD: state_n = res_ready ? (res_last ? DONE : FILL) : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    pix_ready = state == FILL;
    frame_done = state == DONE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      col <= '0;
      row <= '0;
      win_data <= '0;
      kern_sel_q <= '0;
      res_data <= '0;
      res_valid <= 1'b0;
      res_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        kern_sel_q <= kernel_sel;
        col <= '0;
        row <= '0;
      end
      if (acc) begin
        win_data <= {win_data[63:48], lb1, win_data[39:24], lb0, win_data[15:0], pix_data};
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
      end
      if (state == CAPT) begin
        res_data <= conv_data;
        res_valid <= 1'b1;
        // only the final pixel of the frame wraps both counters back to the origin
        res_last <= col == '0 && row == '0;
      end
      if (state == HOLD && res_ready) begin
        res_valid <= 1'b0;
        res_last <= 1'b0;
      end
    end
endmodule
